proc_alu_arb: RTL
=================

PROC_ALU_ARB -- requirements
Module: proc_alu_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter ISA_DPTH, default 64, opcode space; opcode width OPW = $clog2(ISA_DPTH) (6 at default).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req0_valid / i_req1_valid  input  1  requester N has an ALU operation pending.
REQ-006 o_req0_ready / o_req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 i_req0_opcode / i_req1_opcode  input  OPW  ALU opcode of requester N.
REQ-008 i_req0_data_a, i_req0_data_b, i_req1_data_a, i_req1_data_b  input  DATA_WIDTH  operands of requester N.
REQ-009 o_rsp_valid  output  1  result available.
REQ-010 i_rsp_ready  input  1  consumer accepts the result.
REQ-011 o_rsp_data  output  DATA_WIDTH  registered ALU result.
REQ-012 o_rsp_id  output  1  requester index (0/1) that owns o_rsp_data.

Function
REQ-013 The block SHALL share one proc_alu instance between two requesters using an FSM with states IDLE, EXEC, RESP.
REQ-014 IDLE: if any i_reqN_valid, the block SHALL grant one requester, assert its o_reqN_ready combinationally in that cycle only, latch its opcode/operands/id, and go to EXEC; otherwise it stays in IDLE.
REQ-015 Arbitration SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted.
REQ-016 The last-granted pointer SHALL update only on a grant; after reset it is 1, so req0 wins the first tie.
REQ-017 At most one o_reqN_ready SHALL be high in any cycle; both are low outside IDLE.
REQ-018 EXEC: the ALU SHALL evaluate the latched operands; at the clock edge the result is registered into o_rsp_data, the id into o_rsp_id, and the FSM goes to RESP.
REQ-019 RESP: o_rsp_valid SHALL be 1; o_rsp_data and o_rsp_id SHALL stay stable until i_rsp_ready=1, then the FSM returns to IDLE with o_rsp_valid=0 on the next cycle.
REQ-020 Latency: a grant in cycle N SHALL give o_rsp_valid=1 in cycle N+2; peak throughput is one operation per 3 cycles.
REQ-021 ALU arithmetic: opcode 0 gives a+b truncated to DATA_WIDTH (carry discarded, wrap-around); every other opcode gives 0.
REQ-022 A requester deasserting valid before ready is a protocol violation; the block need not handle it, but an unaccepted request SHALL never be latched.
REQ-023 i_rsp_ready outside RESP SHALL be ignored; i_reqN_valid outside IDLE SHALL be ignored without loss (the request is retried in the next IDLE).

Reset
REQ-024 While i_rst_n=0: state=IDLE, o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, last-granted pointer=1, latched operands=0, both readys=0.
REQ-025 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response produced after release.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (IDLE/EXEC/RESP) and the opcode constant ALU_OP_ADD=0, for reuse by the ALU and its controllers.
REQ-027 The one sub-module SHALL be proc_alu, instantiated once with DATA_WIDTH and ISA_DPTH passed through; the arbiter SHALL contain no arithmetic of its own.

Verification
REQ-028 req0 only, opcode 0, a=5, b=7, i_rsp_ready=1 -> o_req0_ready pulse in cycle N; o_rsp_valid in N+2 with data=12, id=0.
REQ-029 Both valid after reset: req0 (3+4), req1 (10+20) -> req0 granted first (rsp 7, id 0), then req1 (rsp 30, id 1); a third tie grants req0.
REQ-030 Wrap-around: a=32'hFFFF_FFFF, b=1 -> rsp 0; opcode 6'h05, a=9, b=9 -> rsp 0.
REQ-031 Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid, data and id stable; no new ready granted; the request accepted the cycle after i_rsp_ready=1.
REQ-032 Reset pulse in EXEC -> o_rsp_valid stays 0 after release; the next req1 request (1+1) returns 2 with id 1.
REQ-033 Assertion checks on every cycle: readys one-hot-or-zero, ready only in IDLE, o_rsp_valid only in RESP.

Source files
------------

// File: rtl/proc_alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM states, opcode constants
// and the round-robin pick used in IDLE.
package proc_alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int ALU_OP_ADD = 0;

   // last = index granted most recently; on a tie the other requester wins.
   function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic last);
      logic [1:0] g;
      g[0] = v0 & (~v1 | last);
      g[1] = v1 & (~v0 | ~last);
      return g;
   endfunction

endpackage

// File: rtl/proc_alu_arb_if.sv
// Request/response bus of proc_alu_arb; slave side faces the arbiter,
// master side faces the requesters and the result consumer.
interface proc_alu_arb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ISA_DPTH   = 64
);
   localparam int OPW = $clog2(ISA_DPTH);

   logic                  i_req0_valid;
   logic                  o_req0_ready;
   logic [OPW-1:0]        i_req0_opcode;
   logic [DATA_WIDTH-1:0] i_req0_data_a;
   logic [DATA_WIDTH-1:0] i_req0_data_b;
   logic                  i_req1_valid;
   logic                  o_req1_ready;
   logic [OPW-1:0]        i_req1_opcode;
   logic [DATA_WIDTH-1:0] i_req1_data_a;
   logic [DATA_WIDTH-1:0] i_req1_data_b;
   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [DATA_WIDTH-1:0] o_rsp_data;
   logic                  o_rsp_id;

   modport slave (
      input  i_req0_valid, i_req0_opcode, i_req0_data_a, i_req0_data_b,
      input  i_req1_valid, i_req1_opcode, i_req1_data_a, i_req1_data_b,
      input  i_rsp_ready,
      output o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_data, o_rsp_id
   );

   modport master (
      output i_req0_valid, i_req0_opcode, i_req0_data_a, i_req0_data_b,
      output i_req1_valid, i_req1_opcode, i_req1_data_a, i_req1_data_b,
      output i_rsp_ready,
      input  o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_data, o_rsp_id
   );

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU shared by the arbiter: ADD wraps at DATA_WIDTH, all
// other opcodes yield zero.
module proc_alu
   import proc_alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ISA_DPTH   = 64,
   localparam int OPW       = $clog2(ISA_DPTH)
) (
   input  logic [OPW-1:0]        i_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_res
);

   always_comb begin
      o_res = '0;
      if (i_op == OPW'(ALU_OP_ADD)) o_res = i_a + i_b;
   end

endmodule

// File: rtl/proc_alu_arb.sv
// Two-requester round-robin front end for one proc_alu: IDLE grants and
// latches, EXEC registers the result, RESP holds it until accepted.
module proc_alu_arb
   import proc_alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ISA_DPTH   = 64
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   proc_alu_arb_if.slave bus
);

   localparam int OPW = $clog2(ISA_DPTH);

   arb_state_e            state_q;
   logic                  last_q;
   logic                  id_q;
   logic [OPW-1:0]        op_q;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic                  rsp_valid_q;
   logic                  rsp_id_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;

   logic [1:0]            gnt;
   logic [OPW-1:0]        op_d;
   logic [DATA_WIDTH-1:0] a_d, b_d;
   logic [DATA_WIDTH-1:0] alu_res;

   // Readys are combinational from state and valids; gated in reset so
   // nothing looks accepted while the block is held.
   always_comb begin
      gnt = 2'b00;
      if (i_rst_n && state_q == IDLE)
         gnt = rr_grant(bus.i_req0_valid, bus.i_req1_valid, last_q);
      op_d = gnt[1] ? bus.i_req1_opcode : bus.i_req0_opcode;
      a_d  = gnt[1] ? bus.i_req1_data_a : bus.i_req0_data_a;
      b_d  = gnt[1] ? bus.i_req1_data_b : bus.i_req0_data_b;
   end

   assign bus.o_req0_ready = gnt[0];
   assign bus.o_req1_ready = gnt[1];
   assign bus.o_rsp_valid  = rsp_valid_q;
   assign bus.o_rsp_data   = rsp_data_q;
   assign bus.o_rsp_id     = rsp_id_q;

   proc_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .ISA_DPTH   (ISA_DPTH)
   ) u_alu (
      .i_op  (op_q),
      .i_a   (a_q),
      .i_b   (b_q),
      .o_res (alu_res)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|gnt) begin
                  op_q    <= op_d;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  id_q    <= gnt[1];
                  last_q  <= gnt[1];
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q  <= alu_res;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
